// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one outstanding word-wide request with byte enables,
// load alignment/extension, misalignment detection and a bounded wait for ack.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [4:0]  op_code,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_tag,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_tag,
    output logic        stall,
    output logic        misalign,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [4:0] OP_LW  = 5'b01100;
    localparam logic [4:0] OP_LH  = 5'b01101;
    localparam logic [4:0] OP_LHU = 5'b01110;
    localparam logic [4:0] OP_LB  = 5'b01111;
    localparam logic [4:0] OP_LBU = 5'b10000;
    localparam logic [4:0] OP_SW  = 5'b10001;
    localparam logic [4:0] OP_SH  = 5'b10010;
    localparam logic [4:0] OP_SB  = 5'b10011;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        ld_q, sgn_q;
    logic [1:0]  sz_q, k_q;
    logic [4:0]  tag_q;

    logic        op_ready_q, mem_req_q, mem_we_q, wb_valid_q, misalign_q, timeout_q;
    logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [3:0]  mem_be_q;
    logic [4:0]  wb_tag_q;

    logic        dec_mem, dec_ld, dec_sgn, dec_mis;
    logic [1:0]  dec_sz;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    always_comb begin
        dec_mem = 1'b1;
        dec_ld  = 1'b0;
        dec_sgn = 1'b0;
        dec_sz  = SZ_B;
        unique case (op_code)
            OP_LW:   begin dec_ld = 1'b1; dec_sz = SZ_W; end
            OP_LH:   begin dec_ld = 1'b1; dec_sz = SZ_H; dec_sgn = 1'b1; end
            OP_LHU:  begin dec_ld = 1'b1; dec_sz = SZ_H; end
            OP_LB:   begin dec_ld = 1'b1; dec_sz = SZ_B; dec_sgn = 1'b1; end
            OP_LBU:  begin dec_ld = 1'b1; dec_sz = SZ_B; end
            OP_SW:   dec_sz = SZ_W;
            OP_SH:   dec_sz = SZ_H;
            OP_SB:   dec_sz = SZ_B;
            default: dec_mem = 1'b0;
        endcase

        dec_mis = ((dec_sz == SZ_W) && (addr[1:0] != 2'b00)) ||
                  ((dec_sz == SZ_H) && addr[0]);

        case (dec_sz)
            SZ_B:    begin dec_be = 4'b0001 << addr[1:0]; dec_wdata = {4{store_data[7:0]}}; end
            SZ_H:    begin dec_be = 4'b0011 << addr[1:0]; dec_wdata = {2{store_data[15:0]}}; end
            default: begin dec_be = 4'b1111;              dec_wdata = store_data; end
        endcase
    end

    // Lane extraction works from the latched offset so the result matches the issued request.
    logic [31:0] lane, ld_data;

    always_comb begin
        lane = mem_rdata >> {k_q, 3'b000};
        case (sz_q)
            SZ_B:    ld_data = {{24{sgn_q & lane[7]}}, lane[7:0]};
            SZ_H:    ld_data = {{16{sgn_q & lane[15]}}, lane[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ld_q        <= 1'b0;
            sgn_q       <= 1'b0;
            sz_q        <= SZ_B;
            k_q         <= '0;
            tag_q       <= '0;
            op_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_tag_q    <= '0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_valid && dec_mem) begin
                        ld_q       <= dec_ld;
                        sgn_q      <= dec_sgn;
                        sz_q       <= dec_sz;
                        k_q        <= addr[1:0];
                        tag_q      <= rd_tag;
                        cnt_q      <= '0;
                        op_ready_q <= 1'b0;
                        if (dec_mis) begin
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ~dec_ld;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= dec_be;
                            mem_wdata_q <= dec_wdata;
                        end
                    end
                end
                REQ: begin
                    // Ack wins over an expiring counter in the same cycle.
                    if (mem_ack) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        if (ld_q) begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= ld_data;
                            wb_tag_q   <= tag_q;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    op_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    op_ready_q <= 1'b1;
                    mem_req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = op_ready_q;
    assign stall     = ~op_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_tag    = wb_tag_q;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset sequence,
// and randomized ops checked against a byte-arithmetic reference model.
module tb_mem_access_unit;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready;
    logic [4:0]  op_code, rd_tag;
    logic [31:0] addr, store_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, stall, misalign, timeout;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .addr(addr), .store_data(store_data), .rd_tag(rd_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag), .stall(stall),
        .misalign(misalign), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          reqcnt, we, be, unstable, stall_bad, chk_wd;
        int          wbv_cnt, wbv_cyc, mis_cnt, mis_cyc, to_cnt, to_cyc, rdy_cyc;
        logic [31:0] maddr, wdata, wb_data;
        logic [4:0]  wb_tag;
    } obs_t;

    // kind: 0 load ok, 1 store ok, 2 misaligned, 3 timeout, 4 ignored opcode
    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a, sd, rd;
        int          ack_on, kind;
        logic [3:0]  be;
        logic [31:0] maddr, wd, wbd;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one op for one cycle, then observe the unit cycle by cycle until op_ready.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] tag, input logic [31:0] rd, input int ack_on,
                          output obs_t o);
        o = '0;
        op_valid = 1'b1; op_code = op; addr = a; store_data = sd; rd_tag = tag;
        tick;
        op_valid = 1'b0; op_code = 5'd0; addr = $urandom; store_data = $urandom;
        for (int c = 1; c <= 14; c++) begin
            if (stall !== !op_ready) o.stall_bad++;
            if (mem_req) begin
                o.reqcnt++;
                if (o.reqcnt == 1) begin
                    o.we = int'(mem_we); o.be = int'(mem_be); o.maddr = mem_addr; o.wdata = mem_wdata;
                end else if (o.we != int'(mem_we) || o.be != int'(mem_be) ||
                             o.maddr != mem_addr || o.wdata != mem_wdata) begin
                    o.unstable = 1;
                end
                if (o.reqcnt == ack_on) begin mem_ack = 1'b1; mem_rdata = rd; end
            end
            if (wb_valid) begin o.wbv_cnt++; o.wbv_cyc = c; o.wb_data = wb_data; o.wb_tag = wb_tag; end
            if (misalign) begin o.mis_cnt++; o.mis_cyc = c; end
            if (timeout) begin o.to_cnt++; o.to_cyc = c; end
            if (op_ready) begin o.rdy_cyc = c; break; end
            tick;
            mem_ack = 1'b0; mem_rdata = $urandom;
        end
    endtask

    task automatic compare(input string n, input obs_t g, input obs_t e);
        check({n, ".rdy_cyc"}, g.rdy_cyc, e.rdy_cyc);
        check({n, ".reqcnt"}, g.reqcnt, e.reqcnt);
        check({n, ".wbv_cnt"}, g.wbv_cnt, e.wbv_cnt);
        check({n, ".mis_cnt"}, g.mis_cnt, e.mis_cnt);
        check({n, ".to_cnt"}, g.to_cnt, e.to_cnt);
        check({n, ".stall"}, g.stall_bad, 0);
        check({n, ".stable"}, g.unstable, 0);
        if (e.wbv_cnt != 0) begin
            check({n, ".wbv_cyc"}, g.wbv_cyc, e.wbv_cyc);
            check({n, ".wb_data"}, g.wb_data, e.wb_data);
            check({n, ".wb_tag"}, 32'(g.wb_tag), 32'(e.wb_tag));
        end
        if (e.mis_cnt != 0) check({n, ".mis_cyc"}, g.mis_cyc, e.mis_cyc);
        if (e.to_cnt != 0) check({n, ".to_cyc"}, g.to_cyc, e.to_cyc);
        if (e.reqcnt != 0) begin
            check({n, ".maddr"}, g.maddr, e.maddr);
            check({n, ".be"}, g.be, e.be);
            check({n, ".we"}, g.we, e.we);
            if (e.chk_wd != 0) check({n, ".wdata"}, g.wdata, e.wdata);
        end
    endtask

    // Reference: byte counts, offsets and arithmetic on whole words.
    function automatic obs_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                                   input logic [31:0] rd, input logic [4:0] tag, input int ack_on);
        obs_t e;
        int n, k;
        bit ld, sg;
        longint v, full;
        e = '0; n = 0; ld = 0; sg = 0;
        k = int'(a % 4);
        case (op)
            5'b01100: begin n = 4; ld = 1; end
            5'b01101: begin n = 2; ld = 1; sg = 1; end
            5'b01110: begin n = 2; ld = 1; end
            5'b01111: begin n = 1; ld = 1; sg = 1; end
            5'b10000: begin n = 1; ld = 1; end
            5'b10001: n = 4;
            5'b10010: n = 2;
            5'b10011: n = 1;
            default:  n = 0;
        endcase
        if (n == 0) begin e.rdy_cyc = 1; return e; end
        if (k % n != 0) begin e.mis_cnt = 1; e.mis_cyc = 1; e.rdy_cyc = 2; return e; end
        e.maddr = a - 32'(k);
        e.be = ((1 << n) - 1) << k;
        e.we = ld ? 0 : 1;
        e.chk_wd = ld ? 0 : 1;
        if (n == 1) e.wdata = (sd & 32'hFF) * 32'h0101_0101;
        else if (n == 2) e.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
        else e.wdata = sd;
        if (ack_on >= 1 && ack_on <= MAXW) begin
            e.reqcnt = ack_on;
            e.rdy_cyc = ack_on + 2;
            if (ld) begin
                full = longint'(1) << (8 * n);
                v = longint'(rd >> (8 * k)) % full;
                if (sg && v >= full / 2) v = v - full;
                e.wbv_cnt = 1; e.wbv_cyc = ack_on + 1; e.wb_data = 32'(v); e.wb_tag = tag;
            end
        end else begin
            e.reqcnt = MAXW; e.to_cnt = 1; e.to_cyc = MAXW + 1; e.rdy_cyc = MAXW + 2;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int ack_on, input int kind,
                                input logic [3:0] be, input logic [31:0] maddr,
                                input logic [31:0] wd, input logic [31:0] wbd);
        vec_t v;
        v.op = op; v.a = a; v.sd = sd; v.rd = rd; v.ack_on = ack_on; v.kind = kind;
        v.be = be; v.maddr = maddr; v.wd = wd; v.wbd = wbd;
        return v;
    endfunction

    vec_t tbl[14];
    logic [4:0] ops[8] = '{5'b01100, 5'b01101, 5'b01110, 5'b01111,
                           5'b10000, 5'b10001, 5'b10010, 5'b10011};
    logic [4:0] nonmem[4] = '{5'b00000, 5'b00001, 5'b10100, 5'b11111};

    initial begin
        obs_t g, e;
        logic [4:0] op, tag;
        logic [31:0] a, sd, rd;
        int ack_on, bad;

        tbl[0]  = mk(5'b01111, 32'h1003, 32'h0,         32'h80FF_0000, 1, 0, 4'b1000, 32'h1000, 32'h0,         32'hFFFF_FF80);
        tbl[1]  = mk(5'b10000, 32'h1003, 32'h0,         32'h80FF_0000, 1, 0, 4'b1000, 32'h1000, 32'h0,         32'h0000_0080);
        tbl[2]  = mk(5'b01110, 32'h0002, 32'h0,         32'hBEEF_1234, 1, 0, 4'b1100, 32'h0000, 32'h0,         32'h0000_BEEF);
        tbl[3]  = mk(5'b10010, 32'h0006, 32'h1234_ABCD, 32'h0,         1, 1, 4'b1100, 32'h0004, 32'hABCD_ABCD, 32'h0);
        tbl[4]  = mk(5'b01100, 32'h0002, 32'h0,         32'h0,         1, 2, 4'b0000, 32'h0,    32'h0,         32'h0);
        tbl[5]  = mk(5'b01100, 32'h0010, 32'h0,         32'h0,         0, 3, 4'b1111, 32'h0010, 32'h0,         32'h0);
        tbl[6]  = mk(5'b01100, 32'h0010, 32'h0,         32'hCAFE_F00D, 4, 0, 4'b1111, 32'h0010, 32'h0,         32'hCAFE_F00D);
        tbl[7]  = mk(5'b01101, 32'h0002, 32'h0,         32'h8000_1234, 2, 0, 4'b1100, 32'h0000, 32'h0,         32'hFFFF_8000);
        tbl[8]  = mk(5'b10011, 32'h0001, 32'hAABB_CC5A, 32'h0,         3, 1, 4'b0010, 32'h0000, 32'h5A5A_5A5A, 32'h0);
        tbl[9]  = mk(5'b10001, 32'h0008, 32'hDEAD_BEEF, 32'h0,         1, 1, 4'b1111, 32'h0008, 32'hDEAD_BEEF, 32'h0);
        tbl[10] = mk(5'b10010, 32'h0003, 32'h0,         32'h0,         1, 2, 4'b0000, 32'h0,    32'h0,         32'h0);
        tbl[11] = mk(5'b01111, 32'h0000, 32'h0,         32'h0000_007F, 1, 0, 4'b0001, 32'h0000, 32'h0,         32'h0000_007F);
        tbl[12] = mk(5'b00000, 32'h0000, 32'h0,         32'h0,         1, 4, 4'b0000, 32'h0,    32'h0,         32'h0);
        tbl[13] = mk(5'b01110, 32'h0000, 32'h0,         32'h1234_ABCD, 1, 0, 4'b0011, 32'h0000, 32'h0,         32'h0000_ABCD);

        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; addr = '0; store_data = '0;
        rd_tag = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("rst.op_ready", op_ready, 1);
        check("rst.stall", stall, 0);
        check("rst.flags", {mem_req, mem_we, mem_be, wb_valid, misalign, timeout, wb_tag}, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        check("rst.wb_data", wb_data, 0);
        tick;
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 14; i++) begin
            tag = 5'(i + 3);
            run_op(tbl[i].op, tbl[i].a, tbl[i].sd, tag, tbl[i].rd, tbl[i].ack_on, g);
            e = '0;
            case (tbl[i].kind)
                0, 1: begin
                    e.reqcnt = tbl[i].ack_on; e.rdy_cyc = tbl[i].ack_on + 2;
                    e.maddr = tbl[i].maddr; e.be = int'(tbl[i].be);
                    if (tbl[i].kind == 0) begin
                        e.wbv_cnt = 1; e.wbv_cyc = tbl[i].ack_on + 1;
                        e.wb_data = tbl[i].wbd; e.wb_tag = tag;
                    end else begin
                        e.we = 1; e.chk_wd = 1; e.wdata = tbl[i].wd;
                    end
                end
                2: begin e.mis_cnt = 1; e.mis_cyc = 1; e.rdy_cyc = 2; end
                3: begin
                    e.reqcnt = MAXW; e.maddr = tbl[i].maddr; e.be = int'(tbl[i].be);
                    e.to_cnt = 1; e.to_cyc = MAXW + 1; e.rdy_cyc = MAXW + 2;
                end
                default: e.rdy_cyc = 1;
            endcase
            compare($sformatf("tbl%0d", i), g, e);
        end

        // Reset landing in the second REQ cycle, then a stray ack afterwards.
        op_valid = 1'b1; op_code = 5'b01100; addr = 32'h40; rd_tag = 5'd9;
        tick;
        op_valid = 1'b0;
        check("rstmid.req1", mem_req, 1);
        tick;
        check("rstmid.req2", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.req_drop", mem_req, 0);
        check("rstmid.ready", {op_ready, stall}, 2'b10);
        tick;
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (mem_req || wb_valid || misalign || timeout || !op_ready) bad++;
        end
        mem_ack = 1'b0;
        check("rstmid.late_ack", bad, 0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) op = nonmem[$urandom_range(0, 3)];
            else op = ops[$urandom_range(0, 7)];
            a = $urandom; sd = $urandom; rd = $urandom; tag = 5'($urandom);
            ack_on = $urandom_range(0, 5);
            run_op(op, a, sd, tag, rd, ack_on, g);
            e = model(op, a, sd, rd, tag, ack_on);
            compare($sformatf("rnd%0d", i), g, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
